rst_sequencer: RTL and testbench

Parametrised reset generator, successor to the single-bit polarity flop. Takes the board-level asynchronous active-low reset and synchronises its deassertion to i_aclk. Releases NUM_CH downstream reset domains in a staggered order, each with per-channel output polarity. Adds a synchronous software-reset request and a ready flag; sits at the top of the SoC ahead of the core, bus and peripheral resets.

---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/rst_sync.sv | 29 ++
 rtl/rst_sequencer.sv | 117 +++++++++++
 tb/tb_rst_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encodings and counter sizing.
// Latency: n/a (package).
// Backpressure: n/a.
package rst_seq_pkg;

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    typedef enum logic [1:0] {
        ASSERT  = ST_ASSERT,
        HOLD    = ST_HOLD,
        RELEASE = ST_RELEASE,
        RUN     = ST_RUN
    } state_t;

    // Wide enough for the longest software-reset-to-last-release span plus headroom.
    function automatic int cnt_width(input int sw_cycles, input int hold_cycles,
                                     input int num_ch, input int stagger_cycles);
        return $clog2(sw_cycles + hold_cycles + (num_ch - 1) * stagger_cycles + 2);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asynchronous assertion, deassertion retimed to clk.
// Latency: rst_sync_n rises after STAGES clk edges following arst_n release.
// Backpressure: none.
// Ports: clk (clock), arst_n (raw async active-low reset), rst_sync_n (synchronised reset).
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic rst_sync_n
);

    if (STAGES < 2) begin : g_param_err
        $error("rst_sync: STAGES must be >= 2");
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = chain[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: syncs board reset, then releases NUM_CH reset domains staggered in time.
// Latency: channel k released SYNC_STAGES+HOLD_CYCLES+k*STAGGER_CYCLES edges after i_rst_n rises.
// Backpressure: none; i_sw_rst restarts the sequence with SW_RST_CYCLES extra assertion.
// Ports: i_aclk, i_rst_n (async active-low), i_sw_rst (sync active-high),
//        o_rst_vec (per-channel reset, polarity from POL_MASK), o_ready (all channels released).
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int                 NUM_CH         = 4,
    parameter int                 SYNC_STAGES    = 2,
    parameter int                 HOLD_CYCLES    = 16,
    parameter int                 STAGGER_CYCLES = 4,
    parameter int                 SW_RST_CYCLES  = 8,
    parameter logic [NUM_CH-1:0]  POL_MASK       = '0
) (
    input  logic              i_aclk,
    input  logic              i_rst_n,
    input  logic              i_sw_rst,
    output logic [NUM_CH-1:0] o_rst_vec,
    output logic              o_ready
);

    if (NUM_CH < 1 || SYNC_STAGES < 2 || HOLD_CYCLES < 1 || SW_RST_CYCLES < 1
        || STAGGER_CYCLES < 0) begin : g_param_err
        $error("rst_sequencer: illegal parameter value");
    end

    localparam int CNT_W = cnt_width(SW_RST_CYCLES, HOLD_CYCLES, NUM_CH, STAGGER_CYCLES);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SW_CNT  = cnt_t'(SW_RST_CYCLES);
    localparam cnt_t CNT_MAX = '1;

    logic        rst_sync_n;
    state_t      state, state_nxt;
    cnt_t        cnt, cnt_nxt, cnt_inc;
    logic [NUM_CH-1:0] rel, rel_nxt;
    logic        ready, ready_nxt;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (i_aclk),
        .arst_n     (i_rst_n),
        .rst_sync_n (rst_sync_n)
    );

    always_ff @(posedge i_aclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= HOLD;
            cnt   <= '0;
            rel   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rel   <= rel_nxt;
            ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rel_nxt   = rel;
        ready_nxt = ready;
        cnt_inc   = cnt + 1'b1;

        // Software reset overrides everything, including a release due on this edge.
        if (i_sw_rst) begin
            state_nxt = ASSERT;
            cnt_nxt   = '0;
            rel_nxt   = '0;
            ready_nxt = 1'b0;
        end else begin
            case (state)
                ASSERT: begin
                    // Counter restarts in HOLD so release timing matches power-on.
                    if (cnt_inc == SW_CNT) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HOLD, RELEASE: begin
                    cnt_nxt = cnt_inc;
                    // OR-in keeps release monotonic.
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (cnt_inc >= cnt_t'(HOLD_CYCLES + k * STAGGER_CYCLES)) begin
                            rel_nxt[k] = 1'b1;
                        end
                    end
                    if (&rel_nxt) begin
                        state_nxt = RUN;
                        ready_nxt = 1'b1;
                    end else if (rel_nxt[0]) begin
                        state_nxt = RELEASE;
                    end
                end
                RUN: begin
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = HOLD;
                end
            endcase
        end
    end

    // Polarity bit set flips the channel to active-high.
    assign o_rst_vec = rel ^ POL_MASK;
    assign o_ready   = ready;

endmodule

// File: tb/tb_rst_sequencer.sv
module tb_rst_sequencer;

    localparam int BIG = 1 << 30;
    localparam int SYNC_P [3] = '{2, 2, 3};
    localparam int STAG_P [3] = '{4, 4, 0};
    localparam int NCH_P  [3] = '{4, 4, 1};
    localparam int HOLD_P = 16;
    localparam int SW_P   = 8;
    localparam logic [3:0] MASK_P [3] = '{4'b0000, 4'b1010, 4'b0000};

    logic       clk;
    logic [2:0] rn;
    logic [2:0] sw;
    logic [3:0] out_a, out_b;
    logic [0:0] out_c;
    logic [2:0] rdy;
    logic [3:0] outv [3];

    int ecnt;
    int base [3];
    int rcnt [3];
    int vectors;
    int miscompares;

    rst_sequencer #(
        .NUM_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(4),
        .SW_RST_CYCLES(8), .POL_MASK(4'b0000)
    ) u_dut_a (
        .i_aclk(clk), .i_rst_n(rn[0]), .i_sw_rst(sw[0]), .o_rst_vec(out_a), .o_ready(rdy[0])
    );

    rst_sequencer #(
        .NUM_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(4),
        .SW_RST_CYCLES(8), .POL_MASK(4'b1010)
    ) u_dut_b (
        .i_aclk(clk), .i_rst_n(rn[1]), .i_sw_rst(sw[1]), .o_rst_vec(out_b), .o_ready(rdy[1])
    );

    rst_sequencer #(
        .NUM_CH(1), .SYNC_STAGES(3), .HOLD_CYCLES(16), .STAGGER_CYCLES(0),
        .SW_RST_CYCLES(8), .POL_MASK(1'b0)
    ) u_dut_c (
        .i_aclk(clk), .i_rst_n(rn[2]), .i_sw_rst(sw[2]), .o_rst_vec(out_c), .o_ready(rdy[2])
    );

    assign outv[0] = out_a;
    assign outv[1] = out_b;
    assign outv[2] = {3'b000, out_c};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, ecnt, got, exp);
        end
    endtask

    // Reference model: each instance tracks only the edge at which channel 0 is due.
    // Power-on: first edge with reset high is edge 1, channel 0 due at edge SYNC+HOLD.
    // Software reset seen at edge S (once synchroniser has released): due at S+SW+HOLD.
    always @(posedge clk) begin
        ecnt++;
        for (int i = 0; i < 3; i++) begin
            if (!rn[i]) begin
                rcnt[i] = 0;
                base[i] = BIG;
            end else begin
                rcnt[i]++;
                if (rcnt[i] == 1) begin
                    base[i] = ecnt + SYNC_P[i] - 1 + HOLD_P;
                end else if (sw[i] && rcnt[i] > SYNC_P[i]) begin
                    base[i] = ecnt + SW_P + HOLD_P;
                end
            end
        end
    end

    function automatic logic [3:0] exp_out(input int i);
        logic [3:0] rel;
        rel = '0;
        for (int k = 0; k < NCH_P[i]; k++) begin
            if (rn[i] && ecnt >= base[i] + k * STAG_P[i]) rel[k] = 1'b1;
        end
        return rel ^ MASK_P[i];
    endfunction

    function automatic logic exp_rdy(input int i);
        return rn[i] && (ecnt >= base[i] + (NCH_P[i] - 1) * STAG_P[i]);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_vec%0d", i), 32'(outv[i]), 32'(exp_out(i)));
            chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(exp_rdy(i)));
        end
        case (ecnt)
            17:  chk("a_pre_rel", 32'(out_a), 32'h0);
            18:  chk("a_ch0_rel", 32'(out_a), 32'h1);
            19:  chk("c_sw_blocks_rel", 32'(out_c), 32'h0);
            29:  chk("a_rdy_early", 32'(rdy[0]), 32'h0);
            30: begin
                chk("a_rdy_on", 32'(rdy[0]), 32'h1);
                chk("b_pol_run", 32'(out_b), 32'h5);
            end
            43:  chk("c_rel_after_sw", 32'(out_c), 32'h1);
            123: chk("a_sw_pre", 32'(out_a), 32'h0);
            124: chk("a_sw_ch0", 32'(out_a), 32'h1);
            127: chk("b_held_pre", 32'(out_b), 32'ha);
            128: chk("b_held_ch0", 32'(out_b), 32'hb);
            136: chk("a_sw_rdy", 32'(rdy[0]), 32'h1);
            140: chk("b_held_rdy", 32'(rdy[1]), 32'h1);
            184: chk("a_mid_release", 32'(out_a), 32'h3);
            203: chk("a_restart_pre", 32'(out_a), 32'h0);
            204: chk("a_restart_ch0", 32'(out_a), 32'h1);
            default: ;
        endcase
    end

    task automatic at_edge(input int n);
        do @(negedge clk); while (ecnt < n);
        #1;
    endtask

    initial begin
        int swl [3];
        int rlow [3];
        ecnt = 0;
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 3; i++) begin
            base[i] = BIG;
            rcnt[i] = 0;
            swl[i] = 0;
            rlow[i] = 0;
        end
        sw = '0;
        rn = 3'b111;
        #1 rn = 3'b000;
        #0.5;
        chk("por_a", 32'(out_a), 32'h0);
        chk("por_b", 32'(out_b), 32'ha);
        chk("por_rdy", 32'(rdy), 32'h0);
        #0.5 rn = 3'b111;

        at_edge(18);  sw[2] = 1'b1;
        at_edge(19);  sw[2] = 1'b0;
        at_edge(99);  sw[1:0] = 2'b11;
        at_edge(100); sw[0] = 1'b0;
        at_edge(104); sw[1] = 1'b0;
        at_edge(160); rn[0] = 1'b0;
        at_edge(161); rn[0] = 1'b1;
        at_edge(184); rn[0] = 1'b0;
        #1;
        chk("async_vec", 32'(out_a), 32'h0);
        chk("async_rdy", 32'(rdy[0]), 32'h0);
        at_edge(186); rn[0] = 1'b1;
        at_edge(210);

        repeat (3000) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (rlow[i] > 0) begin
                    rlow[i]--;
                    if (rlow[i] == 0) rn[i] = 1'b1;
                end else if ($urandom_range(299) == 0) begin
                    rn[i] = 1'b0;
                    rlow[i] = $urandom_range(3, 1);
                end
                if (swl[i] > 0) begin
                    sw[i] = 1'b1;
                    swl[i]--;
                end else begin
                    sw[i] = 1'b0;
                    if ($urandom_range(59) == 0) swl[i] = $urandom_range(5, 1);
                end
            end
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
